// File: rtl/updown_counter.sv
// Run/stop modulo-(MAX_COUNT+1) up/down counter with preset load, packed-BCD output and wrap buzzer.
// Optional SEVEN_SEG_EN adds a multiplexed two-digit active-low seven-segment driver.
module updown_counter #(
  parameter int unsigned MAX_COUNT  = 59,
  parameter int unsigned LOAD_VALUE = 30,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned BUZZ_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_down,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  output logic [6:0] count,
  output logic [6:0] bcd,
  output logic       buzzer
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0] seg_out,
  output logic [1:0] anode
`endif
);

  localparam int unsigned CW = 7;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN + 1) : 1;

  logic [CW-1:0] count_q, count_d;
  logic [6:0]    bcd_q, bcd_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] timer_q, timer_d;
  logic          run_q, run_d;
  logic          buzzer_q, buzzer_d;
  logic          run_eff;
  logic          wrap;
  logic [2:0]    tens;
  logic [3:0]    ones;

  // Next-state: load overrides everything but reset; a step happens when the prescaler expires.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap    = 1'b0;
    run_eff = (run_q | start) & ~stop;
    run_d   = run_eff;
    timer_d = (timer_q != '0) ? timer_q - BW'(1) : timer_q;

    if (load) begin
      count_d = CW'(LOAD_VALUE);
      presc_d = '0;
      timer_d = '0;
      run_d   = run_q;
    end else if (run_eff) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (up_down) begin
          if (count_q == CW'(MAX_COUNT)) begin
            count_d = '0;
            wrap    = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = CW'(MAX_COUNT);
            wrap    = 1'b1;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (wrap) begin
      timer_d = BW'(BUZZ_LEN);
    end
    buzzer_d = (timer_d != '0);
  end

  // Compare-subtract binary to BCD on the next count so bcd lands on the same edge.
  always_comb begin
    tens = '0;
    for (int i = 1; i < 8; i++) begin
      if (count_d >= CW'(10 * i)) begin
        tens = 3'(i);
      end
    end
    ones  = 4'(count_d - (CW'(tens) * CW'(10)));
    bcd_d = {tens, ones};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q  <= '0;
      bcd_q    <= '0;
      presc_q  <= '0;
      timer_q  <= '0;
      run_q    <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      bcd_q    <= bcd_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      run_q    <= run_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign count  = count_q;
  assign bcd    = bcd_q;
  assign buzzer = buzzer_q;

`ifdef SEVEN_SEG_EN
  logic [15:0] refresh_q, refresh_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  anode_q, anode_d;
  logic [3:0]  digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Refresh MSB picks the digit: low half shows ones, high half shows tens.
  always_comb begin
    refresh_d = refresh_q + 16'd1;
    digit     = refresh_d[15] ? {1'b0, bcd_d[6:4]} : bcd_d[3:0];
    seg_d     = seg_decode(digit);
    anode_d   = refresh_d[15] ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      refresh_q <= '0;
      seg_q     <= 7'b1111111;
      anode_q   <= 2'b11;
    end else begin
      refresh_q <= refresh_d;
      seg_q     <= seg_d;
      anode_q   <= anode_d;
    end
  end

  assign seg_out = seg_q;
  assign anode   = anode_q;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed scenarios then randomized control
// traffic, all checked against a behavioural timer model.
module tb_updown_counter;

  localparam int MAXC  = 59;
  localparam int LOADV = 30;
  localparam int TDIV  = 1;
  localparam int BLEN  = 4;

  logic       clk = 1'b0;
  logic       rst_n, up_down, start, stop, load;
  logic [6:0] count, bcd;
  logic       buzzer;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_count = 0;
  int m_run   = 0;
  int m_presc = 0;
  int m_timer = 0;
  int buzz_seen;

  always #5 clk = ~clk;

  updown_counter #(
    .MAX_COUNT (MAXC),
    .LOAD_VALUE(LOADV),
    .TICK_DIV  (TDIV),
    .BUZZ_LEN  (BLEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .up_down(up_down),
    .start  (start),
    .stop   (stop),
    .load   (load),
    .count  (count),
    .bcd    (bcd),
    .buzzer (buzzer)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Timer behaviour described directly from the rules: reset, load, run latch, step with wrap.
  task automatic model_edge(input int r, input int ud, input int st, input int sp, input int ld);
    int re;
    if (r != 0) begin
      m_count = 0; m_run = 0; m_presc = 0; m_timer = 0;
    end else if (ld != 0) begin
      m_count = LOADV; m_presc = 0; m_timer = 0;
    end else begin
      re = ((m_run != 0) || (st != 0)) && (sp == 0);
      m_run = re;
      if (m_timer > 0) m_timer--;
      if (re != 0) begin
        m_presc++;
        if (m_presc == TDIV) begin
          m_presc = 0;
          if (ud != 0) m_count = m_count + 1;
          else         m_count = m_count - 1;
          if (m_count > MAXC) begin m_count = 0;    m_timer = BLEN; end
          if (m_count < 0)    begin m_count = MAXC; m_timer = BLEN; end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic cyc(input int r, input int ud, input int st, input int sp, input int ld);
    rst_n = 1'(r); up_down = 1'(ud); start = 1'(st); stop = 1'(sp); load = 1'(ld);
    @(posedge clk);
    model_edge(r, ud, st, sp, ld);
    #1;
    check_eq("count", int'(count), m_count);
    check_eq("bcd", int'(bcd), ((m_count / 10) << 4) | (m_count % 10));
    check_eq("buzzer", int'(buzzer), (m_timer != 0) ? 1 : 0);
    if (buzzer === 1'b1) buzz_seen++;
  endtask

  // Keep running in direction ud until the model reaches target; a timeout is a failure.
  task automatic run_until(input int target, input int ud);
    int n = 0;
    while (m_count != target && n < 200) begin
      cyc(0, ud, 0, 0, 0);
      n++;
    end
    check_eq("reach_target", m_count, target);
  endtask

  initial begin
    rst_n = 1'b0; up_down = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
    @(negedge clk);

    // Reset with start held, then release counting up.
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_bcd", int'(bcd), 0);
    cyc(0, 1, 1, 0, 0);
    check_eq("first_step", int'(count), 1);
    cyc(0, 1, 0, 0, 0);
    check_eq("second_step", int'(count), 2);

    // Up wrap with buzzer length and a BCD spot check.
    run_until(37, 1);
    check_eq("bcd_37", int'(bcd), 7'b0110111);
    run_until(MAXC, 1);
    buzz_seen = 0;
    cyc(0, 1, 0, 0, 0);
    check_eq("up_wrap", int'(count), 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    check_eq("buzz_len_up", buzz_seen, BLEN);

    // Stop/start behaviour.
    run_until(12, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
    check_eq("stop_hold", int'(count), 12);
    cyc(0, 1, 1, 1, 0);
    check_eq("both_hold", int'(count), 12);
    cyc(0, 1, 1, 0, 0);
    check_eq("restart", int'(count), 13);
    cyc(0, 1, 0, 0, 0);
    check_eq("keep_run", int'(count), 14);

    // Load while running.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 1);
      check_eq("load_count", int'(count), LOADV);
      check_eq("load_bcd", int'(bcd), 7'b0110000);
    end
    cyc(0, 1, 0, 0, 0);
    check_eq("after_load", int'(count), 31);

    // Down wrap, then direction reversal.
    run_until(2, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("down_1", int'(count), 1);
    cyc(0, 0, 0, 0, 0);
    check_eq("down_0", int'(count), 0);
    buzz_seen = 0;
    cyc(0, 0, 0, 0, 0);
    check_eq("down_wrap", int'(count), MAXC);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check_eq("buzz_len_down", buzz_seen, BLEN);
    check_eq("down_cont", int'(count), MAXC - 6);
    cyc(0, 1, 0, 0, 0);
    check_eq("reverse", int'(count), MAXC - 5);

    // Reset mid-count clears run.
    run_until(45, 1);
    cyc(1, 1, 0, 0, 0);
    check_eq("mid_rst", int'(count), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    check_eq("idle_after_rst", int'(count), 0);
    cyc(0, 1, 1, 0, 0);
    check_eq("start_after_rst", int'(count), 1);

    // Randomized control traffic; start/stop are kept low during load cycles.
    begin
      int ud = 1;
      for (int i = 0; i < 4000; i++) begin
        int r, ld, st, sp;
        r  = ($urandom_range(0, 199) == 0) ? 1 : 0;
        ld = ($urandom_range(0, 39) == 0) ? 1 : 0;
        st = ($urandom_range(0, 7) == 0) ? 1 : 0;
        sp = ($urandom_range(0, 11) == 0) ? 1 : 0;
        if (ld != 0) begin st = 0; sp = 0; end
        if ($urandom_range(0, 24) == 0) ud = 1 - ud;
        cyc(r, ud, st, sp, ld);
        if (int'(count) > MAXC) check_eq("range", int'(count), MAXC);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Run/stop controlled modulo-(MAX_COUNT+1) up/down counter with preset load, binary-to-packed-BCD conversion and a wrap-around buzzer pulse.
- Used as a seconds-style timer core feeding display and alarm logic.
- All outputs are registered in a single clock domain.

Parameters:
- MAX_COUNT, 59, terminal count. Must be 1..79 so the tens digit fits in 3 bits.
- LOAD_VALUE, 30, value preset by load. Must be <= MAX_COUNT.
- TICK_DIV, 1, enabled clock cycles per count step. Must be >= 1.
- BUZZ_LEN, 4, buzzer pulse length in cycles. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-high; the name is kept for codebase compatibility.
- up_down  in  1  direction: 1 = count up, 0 = count down.
- start  in  1  set run state (level sampled).
- stop  in  1  clear run state (level sampled).
- load  in  1  preset count to LOAD_VALUE.
- count  out  7  binary count value.
- bcd  out  7  packed BCD {tens[2:0], ones[3:0]} of count.
- buzzer  out  1  wrap alarm pulse.

Behaviour:
- Reset: on any rising clk edge with rst_n=1, all registers clear: count=0, bcd=0, buzzer=0, run=0, prescaler=0. Reset has top priority and applies mid-count.
- Control priority per edge: reset > load > stop > start/count.
- Run state:
  - run_eff = (run | start) & ~stop.
  - run register <= run_eff every edge, so start latches run and stop clears it.
  - start and stop both high: stop wins, count holds, run=0.
- Load: load=1 sets count=LOAD_VALUE on that edge, clears the prescaler and the buzzer timer, and leaves run unchanged. No count step occurs in a load cycle.
- Counting: when run_eff=1 and load=0, the prescaler increments. At prescaler==TICK_DIV-1 a step occurs and the prescaler returns to 0. With TICK_DIV=1 the count steps on every edge where run_eff=1, including the edge on which start is first sampled.
- Step up: count==MAX_COUNT -> 0 (wrap); otherwise count+1.
- Step down: count==0 -> MAX_COUNT (wrap); otherwise count-1.
- up_down is sampled at each step; a direction change takes effect on the next step with no extra latency.
- When run_eff=0, count and prescaler hold.
- bcd:
  - Registered, updated on the same edge as count, so bcd always matches count.
  - tens = count/10, ones = count%10, computed by combinational double-dabble or compare-subtract.
  - Example: count 37 -> bcd 7'b011_0111.
- buzzer:
  - A wrap step loads the buzzer timer with BUZZ_LEN; buzzer=1 while the timer is nonzero, and the timer decrements each cycle.
  - A new wrap during an active pulse reloads the timer to BUZZ_LEN.
  - buzzer rises on the same edge as the wrap.
- Outputs are never X after the first reset edge. count is always in 0..MAX_COUNT.

Optional Feature:
- Macro SEVEN_SEG_EN.
- When defined:
  - Extra outputs seg_out[6:0] (active-low segments a..g, gfedcba order) and anode[1:0] (active-low digit select).
  - A 16-bit refresh counter alternates digits every 2^15 cycles: anode=2'b10 shows ones, anode=2'b01 shows tens.
  - Digit decode: 0-9 standard patterns (0 -> 7'b1000000); any other value -> all segments off.
  - Reset: seg_out=7'b1111111, anode=2'b11.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=1 for 2 cycles with start=1 -> count=0, bcd=0, buzzer=0. Release with start=1, up_down=1 -> count=1 on the first edge, then 2, 3, and so on.
- Up wrap: run up from 0 for 60 steps -> count 59 then 0; buzzer=1 for exactly 4 cycles starting at the wrap edge. At count=37, bcd=7'b0110111.
- Stop/start: stop=1 at count=12 -> holds at 12 for 5 cycles. start=stop=1 -> still 12. start=1, stop=0 -> 13 on the next edge. Release start after 1 cycle -> keeps counting.
- Load: load=1 for 5 cycles while running -> count=30 and bcd=7'b0110000 throughout. Release load -> 31 on the next edge.
- Down wrap: up_down=0 from count=2 -> 1, 0, 59; buzzer pulses 4 cycles from the 0->59 edge. Toggle up_down mid-run -> direction reverses on the next step.
- Reset mid-count: rst_n=1 at count=45 while running -> count=0, run=0. Stays 0 with start=0 until start is asserted.
